// File: rtl/cnter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cnter_arbiter
// Purpose  : Shares one SHA-256 compression core (Cnter) between NUM_REQ
//            requesters. A round-robin arbiter grants one job at a time. The
//            winner's H_in/W are latched into core_H_in/core_W and the core is
//            launched by releasing core_reset. The module then waits for
//            core_done and returns core_H_out to the winner over
//            resp_valid/resp_ready.
// Ports    : clk, reset (async, active-low)
//            req_valid/req_ready      per-requester job handshake (one-hot ready)
//            req_H_in  [NUM_REQ*256]  requester i at bits [i*256 +: 256]
//            req_W     [NUM_REQ*2048] requester i at bits [i*2048 +: 2048]
//            resp_valid/resp_ready    per-requester result handshake (one-hot valid)
//            resp_H_out, resp_err     shared result bus
//            core_reset, core_H_in, core_W, core_done, core_H_out  core side
//            busy                     high whenever the FSM is not idle
// Macro    : CNTER_TIMEOUT_EN enables an 8-bit RUN-state watchdog. When it
//            fires, the job is answered with resp_H_out=0 and resp_err=1.
// Revision : 1.0  initial release
// ============================================================================
module cnter_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT_CYC  = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*256-1:0]  req_H_in,
  input  logic [NUM_REQ*2048-1:0] req_W,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [255:0]            resp_H_out,
  output logic                    resp_err,
  output logic                    core_reset,
  output logic [255:0]            core_H_in,
  output logic [2047:0]           core_W,
  input  logic                    core_done,
  input  logic [255:0]            core_H_out,
  output logic                    busy
);

  localparam int C_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int C_IDP_W = C_ID_W + 1;
  localparam int C_CNT_W = $clog2(START_CYCLES + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("cnter_arbiter: NUM_REQ must be 2..8");
  end
  if (START_CYCLES < 1) begin : g_bad_start
    $error("cnter_arbiter: START_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("cnter_arbiter: TIMEOUT_CYC must fit the 8-bit watchdog");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [C_ID_W-1:0]    id_q, id_d;
  logic [C_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 core_reset_q, core_reset_d;
  logic [255:0]         core_H_in_q, core_H_in_d;
  logic [2047:0]        core_W_q, core_W_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [255:0]         resp_H_out_q, resp_H_out_d;
  logic                 resp_err_q, resp_err_d;
  logic                 busy_q, busy_d;
`ifdef CNTER_TIMEOUT_EN
  logic [7:0]           wd_q, wd_d;
`endif

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  logic                 w_found;
  logic [C_ID_W-1:0]    w_grant_id;
  logic [C_IDP_W-1:0]   w_sum;
  logic [C_ID_W-1:0]    w_idx;

  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, rr_ptr_q} + C_IDP_W'(k);
      w_idx = (w_sum >= C_IDP_W'(NUM_REQ)) ? C_ID_W'(w_sum - C_IDP_W'(NUM_REQ))
                                           : w_sum[C_ID_W-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx;
      end
    end
  end

  // Grant is combinational so the handshake completes in the request cycle.
  assign req_ready = (state_q == S_IDLE && w_found) ? (NUM_REQ'(1) << w_grant_id)
                                                    : '0;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    core_reset_d = core_reset_q;
    core_H_in_d  = core_H_in_q;
    core_W_d     = core_W_q;
    resp_valid_d = resp_valid_q;
    resp_H_out_d = resp_H_out_q;
    resp_err_d   = resp_err_q;
`ifdef CNTER_TIMEOUT_EN
    wd_d         = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          core_H_in_d  = req_H_in[w_grant_id*256 +: 256];
          core_W_d     = req_W[w_grant_id*2048 +: 2048];
          id_d         = w_grant_id;
          rr_ptr_d     = (w_grant_id == C_ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
          cnt_d        = '0;
          core_reset_d = 1'b1;
          state_d      = S_START;
        end
      end
      S_START: begin
        // A done left over from the previous job is ignored here.
        core_reset_d = 1'b1;
        if (cnt_q == C_CNT_W'(START_CYCLES - 1)) begin
          cnt_d        = '0;
          core_reset_d = 1'b0;
          state_d      = S_RUN;
`ifdef CNTER_TIMEOUT_EN
          wd_d         = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (core_done) begin
          resp_H_out_d = core_H_out;
          resp_err_d   = 1'b0;
          resp_valid_d = NUM_REQ'(1) << id_q;
          core_reset_d = 1'b1;
          state_d      = S_RESP;
        end
`ifdef CNTER_TIMEOUT_EN
        else if (wd_q == 8'(TIMEOUT_CYC - 1)) begin
          resp_H_out_d = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = NUM_REQ'(1) << id_q;
          core_reset_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        // Only the owner's resp_ready completes the response.
        core_reset_d = 1'b1;
        if (resp_ready[id_q]) begin
          resp_valid_d = '0;
          resp_err_d   = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;
      core_H_in_q  <= '0;
      core_W_q     <= '0;
      resp_valid_q <= '0;
      resp_H_out_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CNTER_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
      core_H_in_q  <= core_H_in_d;
      core_W_q     <= core_W_d;
      resp_valid_q <= resp_valid_d;
      resp_H_out_q <= resp_H_out_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
`ifdef CNTER_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_H_out = resp_H_out_q;
  assign resp_err   = resp_err_q;
  assign core_reset = core_reset_q;
  assign core_H_in  = core_H_in_q;
  assign core_W     = core_W_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cnter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnter_arbiter
// Purpose  : Scoreboard bench for cnter_arbiter with a behavioural Cnter stub.
//            The stub raises done 66 cycles after core_reset falls and returns
//            H_in+1 per word. It can also be told never to finish.
// Revision : 1.0  initial release
// ============================================================================
module tb_cnter_arbiter;

  localparam int N        = 4;
  localparam int SC       = 2;
  localparam int TO       = 128;
  localparam int CORE_LAT = 66;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid, req_ready, resp_valid, resp_ready;
  logic [N*256-1:0]    req_H_in;
  logic [N*2048-1:0]   req_W;
  logic [255:0]        resp_H_out, core_H_in, core_H_out;
  logic                resp_err, core_reset, busy;
  logic                core_done = 1'b0;
  logic [2047:0]       core_W;

  always #5 clk = ~clk;

  cnter_arbiter #(.NUM_REQ(N), .START_CYCLES(SC), .TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_H_in(req_H_in), .req_W(req_W),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_H_out(resp_H_out), .resp_err(resp_err),
    .core_reset(core_reset), .core_H_in(core_H_in), .core_W(core_W),
    .core_done(core_done), .core_H_out(core_H_out), .busy(busy)
  );

  function automatic logic [255:0] plus1(logic [255:0] h);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = h[k*32 +: 32] + 32'd1;
    return r;
  endfunction

  // Core stub
  int stub_cnt = 0;
  bit stub_never = 1'b0;
  assign core_H_out = plus1(core_H_in);
  always @(posedge clk) begin
    #1;
    if (core_reset) begin
      stub_cnt  = 0;
      core_done = 1'b0;
    end else begin
      if (stub_cnt == CORE_LAT && !stub_never) core_done = 1'b1;
      stub_cnt++;
    end
  end

  // Scoreboard and reference model
  typedef struct {
    int            id;
    logic [255:0]  hin;
    logic [2047:0] w;
    logic [255:0]  h;
    bit            err;
    int            t;
    int            lat;
  } exp_t;

  exp_t sbq[$];
  int   grant_log[$];
  int   m_ptr = 0;
  bit   m_busy = 1'b0;
  bit   resp_seen = 1'b0;
  int   edge_n = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) edge_n++;

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int           win;
    exp_t         e;
    if (!reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_H_out", resp_H_out, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_core_H_in", core_H_in, 0);
      chk("rst_core_W_zero", (core_W == '0), 1);
      chk("rst_busy", busy, 0);
      sbq.delete();
      m_busy    = 1'b0;
      m_ptr     = 0;
      resp_seen = 1'b0;
    end else begin
      exp_ready = '0;
      win       = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        if (win >= 0) exp_ready[win] = 1'b1;
      end
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, m_busy);
      if (m_busy && sbq.size() > 0) begin
        chk("core_H_in", core_H_in, sbq[0].hin);
        chk("core_W_match", (core_W == sbq[0].w), 1);
      end
      if (resp_valid != '0) begin
        if (sbq.size() == 0) begin
          chk("resp_unexpected", resp_valid, 0);
        end else begin
          e = sbq[0];
          chk("resp_valid", resp_valid, 256'(1) << e.id);
          chk("resp_H_out", resp_H_out, e.h);
          chk("resp_err", resp_err, e.err);
          if (!resp_seen) chk("latency", edge_n - e.t, e.lat);
          resp_seen = 1'b1;
          if (resp_ready[e.id]) begin
            void'(sbq.pop_front());
            m_busy    = 1'b0;
            resp_seen = 1'b0;
          end
        end
      end
      if (win >= 0) begin
        e.id  = win;
        e.hin = req_H_in[win*256 +: 256];
        e.w   = req_W[win*2048 +: 2048];
`ifdef CNTER_TIMEOUT_EN
        e.h   = stub_never ? 256'd0 : plus1(e.hin);
        e.err = stub_never;
`else
        e.h   = plus1(e.hin);
        e.err = 1'b0;
`endif
        e.t   = edge_n + 1;
        e.lat = stub_never ? (SC + TO) : (SC + 1 + CORE_LAT);
        sbq.push_back(e);
        grant_log.push_back(win);
        m_busy = 1'b1;
        m_ptr  = (win + 1) % N;
      end
    end
  end

  // Stimulus
  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_ready & req_valid;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic set_job(int i, logic [31:0] hw);
    req_H_in[i*256 +: 256] = {8{hw}};
    for (int k = 0; k < 64; k++) req_W[i*2048 + k*32 +: 32] = $urandom;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_quiet(int budget);
    int c = 0;
    while (!(req_valid == '0 && !busy && sbq.size() == 0) && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) begin
      total++;
      bad++;
      $display("FAIL wait_quiet: not idle after %0d cycles", budget);
    end
  endtask

  task automatic chk_order(string nm, int base, int a, int b, int c, int d);
    int want[4];
    want = '{a, b, c, d};
    if (grant_log.size() < base + 4) begin
      chk({nm, "_count"}, grant_log.size() - base, 4);
    end else begin
      for (int k = 0; k < 4; k++) chk(nm, grant_log[base + k], want[k]);
    end
  endtask

  initial begin
    int base;
    int got;
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_H_in   = '0;
    req_W      = '0;
    #1;
    do_reset();

    // 1: single job, H_in all zero
    resp_ready = '1;
    base = grant_log.size();
    set_job(0, 32'h0);
    wait_quiet(300);
    chk("t1_grant", (grant_log.size() == base + 1) ? grant_log[base] : -1, 0);

    // 2: all four at once from rr_ptr=0
    do_reset();
    base = grant_log.size();
    for (int i = 0; i < N; i++) set_job(i, 32'(i));
    wait_quiet(600);
    chk_order("t2_order", base, 0, 1, 2, 3);

    // 3: backpressure on requester 1 while 0,2,3 wait (rr_ptr back at 0)
    resp_ready = 4'b1101;
    base = grant_log.size();
    set_job(1, $urandom);
    tick();
    set_job(0, $urandom);
    set_job(2, $urandom);
    set_job(3, $urandom);
    got = 0;
    while (!resp_valid[1] && got < 200) begin
      tick();
      got++;
    end
    chk("t3_resp_seen", resp_valid, 4'b0010);
    repeat (20) tick();
    chk("t3_held_valid", resp_valid, 4'b0010);
    chk("t3_pending", req_valid, 4'b1101);
    resp_ready = '1;
    wait_quiet(900);
    if (grant_log.size() >= base + 4) chk_order("t3_order", base, 1, 2, 3, 0);
    else chk("t3_count", grant_log.size() - base, 4);

    // 4: fairness between 0 and 2
    do_reset();
    base = grant_log.size();
    for (int c = 0; c < 2000 && (grant_log.size() - base) < 4; c++) begin
      if (!req_valid[0]) set_job(0, $urandom);
      if (!req_valid[2]) set_job(2, $urandom);
      tick();
    end
    wait_quiet(300);
    chk_order("t4_order", base, 0, 2, 0, 2);

    // 5: asynchronous reset during RUN of job 3
    do_reset();
    set_job(3, $urandom);
    repeat (30) tick();
    chk("t5_busy_before", busy, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t5_async_core_reset", core_reset, 1);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_resp_valid", resp_valid, 0);
    chk("t5_async_core_H_in", core_H_in, 0);
    req_valid = '0;
    repeat (3) tick();
    reset = 1'b1;
    base = grant_log.size();
    set_job(1, $urandom);
    wait_quiet(300);
    chk("t5_after_grant", (grant_log.size() == base + 1) ? grant_log[base] : -1, 1);

    // 6: core never finishes
    do_reset();
    stub_never = 1'b1;
    set_job(2, $urandom);
`ifdef CNTER_TIMEOUT_EN
    wait_quiet(400);
`else
    repeat (200) tick();
    chk("t6_busy_stuck", busy, 1);
    chk("t6_no_resp", resp_valid, 0);
`endif
    stub_never = 1'b0;
    do_reset();

    // Random traffic
    base = grant_log.size();
    for (int c = 0; c < 20000 && (grant_log.size() - base) < 25; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 6) == 0) set_job(i, $urandom);
        else if (req_valid[i] && ($urandom % 40) == 0) req_valid[i] = 1'b0;
      end
      resp_ready = N'($urandom);
      tick();
    end
    chk("rand_grants_min", (grant_log.size() - base) >= 25, 1);
    resp_ready = '1;
    wait_quiet(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
